// File: rtl/enc_pkg.sv
// Shared types and helpers for the enc_arbiter index-grant block.
package enc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    GRANT = 2'd2
  } state_e;

  // Widest request vector the helpers support; callers size-cast down to N.
  localparam int MAX_N = 256;

  function automatic logic [MAX_N-1:0] onehot_of(input int idx);
    return MAX_N'(1) << idx;
  endfunction

endpackage

// File: rtl/enc_arbiter_if.sv
// Request/grant handshake bundle between a request collector and the arbiter.
interface enc_arbiter_if #(
  parameter int N = 8
) ();
  localparam int W = $clog2(N);

  logic [N-1:0] req_in;
  logic         req_valid;
  logic         req_ready;
  logic [W-1:0] grant_idx;
  logic [N-1:0] grant_onehot;
  logic         none;
  logic         grant_valid;
  logic         grant_ready;

  modport master (
    output req_in, req_valid, grant_ready,
    input  req_ready, grant_idx, grant_onehot, none, grant_valid
  );

  modport slave (
    input  req_in, req_valid, grant_ready,
    output req_ready, grant_idx, grant_onehot, none, grant_valid
  );
endinterface

// File: rtl/prio_pick.sv
// Combinational search: first set bit of pend_i at or below start_i, wrapping downward.
module prio_pick #(
  parameter  int N = 8,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] pend_i,
  input  logic [W-1:0] start_i,
  output logic         found_o,
  output logic [W-1:0] idx_o
);

  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  logic [W-1:0]   k;

  // rot[N-1] maps to start_i, lower rot bits walk downward through the indices with wrap.
  always_comb begin
    dbl     = {pend_i, pend_i};
    rot     = N'(dbl >> ({1'b0, start_i} + 1'b1));
    found_o = |rot;
    k       = '0;
    for (int i = 0; i < N; i++) begin
      if (rot[i]) k = W'(i);
    end
    idx_o   = start_i + W'(1) + k;
  end

endmodule

// File: rtl/enc_arbiter.sv
// Registered multi-request encoder: drains a latched request vector one binary index per beat.
module enc_arbiter
  import enc_pkg::*;
#(
  parameter int N       = 8,
  parameter int RR_MODE = 0
) (
  input  logic          clk,
  input  logic          rst,
  enc_arbiter_if.slave  bus
);

  localparam int W = $clog2(N);

  state_e       state_q, state_d;
  logic [N-1:0] pend_q, pend_d;
  logic [N-1:0] oh_q, oh_d;
  logic [W-1:0] idx_q, idx_d;
  logic [W-1:0] rr_ptr_q, rr_ptr_d;
  logic         none_q, none_d;
  logic         gv_q, gv_d;

  logic [W-1:0] start;
  logic         found;
  logic [W-1:0] pick_idx;
  logic [N-1:0] pick_oh;

  // During a handshake the presented grant becomes the new pointer, so search below it directly.
  always_comb begin
    if (RR_MODE == 0)          start = W'(N-1);
    else if (state_q == GRANT) start = idx_q - W'(1);
    else                       start = rr_ptr_q - W'(1);
  end

  prio_pick #(.N(N)) u_pick (
    .pend_i  (pend_q),
    .start_i (start),
    .found_o (found),
    .idx_o   (pick_idx)
  );

  assign pick_oh = N'(onehot_of(int'(pick_idx)));

  always_comb begin
    state_d  = state_q;
    pend_d   = pend_q;
    oh_d     = oh_q;
    idx_d    = idx_q;
    rr_ptr_d = rr_ptr_q;
    none_d   = none_q;
    gv_d     = gv_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          pend_d  = bus.req_in;
          state_d = LOAD;
        end
      end
      LOAD: begin
        gv_d    = 1'b1;
        state_d = GRANT;
        if (found) begin
          idx_d  = pick_idx;
          oh_d   = pick_oh;
          none_d = 1'b0;
          pend_d = pend_q & ~pick_oh;
        end else begin
          idx_d  = '0;
          oh_d   = '0;
          none_d = 1'b1;
        end
      end
      GRANT: begin
        if (bus.grant_ready) begin
          if (RR_MODE != 0 && !none_q) rr_ptr_d = idx_q;
          if (found) begin
            idx_d  = pick_idx;
            oh_d   = pick_oh;
            none_d = 1'b0;
            pend_d = pend_q & ~pick_oh;
          end else begin
            state_d = IDLE;
            gv_d    = 1'b0;
            idx_d   = '0;
            oh_d    = '0;
            none_d  = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      pend_q   <= '0;
      oh_q     <= '0;
      idx_q    <= '0;
      rr_ptr_q <= W'(N-1);
      none_q   <= 1'b0;
      gv_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      pend_q   <= pend_d;
      oh_q     <= oh_d;
      idx_q    <= idx_d;
      rr_ptr_q <= rr_ptr_d;
      none_q   <= none_d;
      gv_q     <= gv_d;
    end
  end

  assign bus.req_ready    = (state_q == IDLE);
  assign bus.grant_valid  = gv_q;
  assign bus.grant_idx    = idx_q;
  assign bus.grant_onehot = oh_q;
  assign bus.none         = none_q;

endmodule

// File: tb/tb_enc_arbiter.sv
// Scoreboard bench for enc_arbiter: fixed-priority N=8, round-robin N=8 and fixed N=16 instances.
`timescale 1ns/1ps
module tb_enc_arbiter;

  typedef struct packed {
    logic        none;
    logic [3:0]  idx;
    logic [15:0] oh;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  enc_arbiter_if #(.N(8))  if_fp ();
  enc_arbiter_if #(.N(8))  if_rr ();
  enc_arbiter_if #(.N(16)) if_16 ();

  enc_arbiter #(.N(8),  .RR_MODE(0)) u_fp (.clk(clk), .rst(rst), .bus(if_fp.slave));
  enc_arbiter #(.N(8),  .RR_MODE(1)) u_rr (.clk(clk), .rst(rst), .bus(if_rr.slave));
  enc_arbiter #(.N(16), .RR_MODE(0)) u_16 (.clk(clk), .rst(rst), .bus(if_16.slave));

  logic [15:0] drv_req  [3];
  logic        drv_vld  [3];
  logic        drv_grdy [3];
  logic [15:0] mon_oh   [3];
  logic [3:0]  mon_idx  [3];
  logic        mon_none [3];
  logic        mon_gv   [3];
  logic        mon_rdy  [3];

  assign if_fp.req_in      = drv_req[0][7:0];
  assign if_fp.req_valid   = drv_vld[0];
  assign if_fp.grant_ready = drv_grdy[0];
  assign if_rr.req_in      = drv_req[1][7:0];
  assign if_rr.req_valid   = drv_vld[1];
  assign if_rr.grant_ready = drv_grdy[1];
  assign if_16.req_in      = drv_req[2];
  assign if_16.req_valid   = drv_vld[2];
  assign if_16.grant_ready = drv_grdy[2];

  assign mon_oh[0]   = {8'h00, if_fp.grant_onehot};
  assign mon_idx[0]  = {1'b0, if_fp.grant_idx};
  assign mon_none[0] = if_fp.none;
  assign mon_gv[0]   = if_fp.grant_valid;
  assign mon_rdy[0]  = if_fp.req_ready;
  assign mon_oh[1]   = {8'h00, if_rr.grant_onehot};
  assign mon_idx[1]  = {1'b0, if_rr.grant_idx};
  assign mon_none[1] = if_rr.none;
  assign mon_gv[1]   = if_rr.grant_valid;
  assign mon_rdy[1]  = if_rr.req_ready;
  assign mon_oh[2]   = if_16.grant_onehot;
  assign mon_idx[2]  = if_16.grant_idx;
  assign mon_none[2] = if_16.none;
  assign mon_gv[2]   = if_16.grant_valid;
  assign mon_rdy[2]  = if_16.req_ready;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  exp_t sb0[$];
  exp_t sb1[$];
  exp_t sb2[$];
  int   rr_ptr_m = 7;

  function automatic int sb_size(input int d);
    case (d)
      0:       return sb0.size();
      1:       return sb1.size();
      default: return sb2.size();
    endcase
  endfunction

  function automatic exp_t sb_front(input int d);
    case (d)
      0:       return sb0[0];
      1:       return sb1[0];
      default: return sb2[0];
    endcase
  endfunction

  task automatic sb_pop(input int d);
    case (d)
      0:       void'(sb0.pop_front());
      1:       void'(sb1.pop_front());
      default: void'(sb2.pop_front());
    endcase
  endtask

  task automatic sb_push(input int d, input exp_t e);
    case (d)
      0:       sb0.push_back(e);
      1:       sb1.push_back(e);
      default: sb2.push_back(e);
    endcase
  endtask

  // Reference ordering: highest index first, or downward from pointer-1 with wrap for round-robin.
  task automatic push_exp(input int d, input logic [15:0] vec, output int beats);
    int          n, start, i;
    logic [15:0] p;
    exp_t        e;
    n     = (d == 2) ? 16 : 8;
    p     = vec;
    beats = 0;
    if (vec == 16'h0) begin
      e = '{none: 1'b1, idx: 4'd0, oh: 16'h0};
      sb_push(d, e);
      beats = 1;
    end
    while (p != 16'h0) begin
      start = (d == 1) ? (rr_ptr_m + n - 1) % n : n - 1;
      for (int j = 0; j < n; j++) begin
        i = (start - j + n) % n;
        if (p[i]) begin
          e = '{none: 1'b0, idx: 4'(i), oh: 16'd1 << i};
          sb_push(d, e);
          p[i] = 1'b0;
          if (d == 1) rr_ptr_m = i;
          beats++;
          break;
        end
      end
    end
  endtask

  // Every presented grant is compared with the scoreboard head; popped only when accepted.
  always @(negedge clk) begin
    if (!rst) begin
      for (int d = 0; d < 3; d++) begin
        if (mon_gv[d]) begin
          if (sb_size(d) == 0) begin
            check_eq($sformatf("sb_nonempty_d%0d", d), 32'(sb_size(d)), 32'd1);
          end else begin
            exp_t e;
            e = sb_front(d);
            check_eq($sformatf("idx_d%0d", d),  32'(mon_idx[d]),  32'(e.idx));
            check_eq($sformatf("oh_d%0d", d),   32'(mon_oh[d]),   32'(e.oh));
            check_eq($sformatf("none_d%0d", d), 32'(mon_none[d]), 32'(e.none));
            if (drv_grdy[d]) sb_pop(d);
          end
        end
      end
    end
  end

  task automatic send(input int d, input logic [15:0] vec, input int stall);
    int beats, cnt, guard;
    guard = 0;
    @(posedge clk); #1;
    while (!mon_rdy[d] && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    check_eq("req_ready_wait", 32'(mon_rdy[d]), 32'd1);
    drv_req[d]  = vec;
    drv_vld[d]  = 1'b1;
    drv_grdy[d] = (stall == 0);
    push_exp(d, vec, beats);
    @(posedge clk); #1;
    drv_vld[d] = 1'b0;
    drv_req[d] = 16'($urandom);
    check_eq("gv_after_accept", 32'(mon_gv[d]), 32'd0);
    @(posedge clk); #1;
    check_eq("gv_first_grant", 32'(mon_gv[d]), 32'd1);
    if (stall > 0) begin
      repeat (stall) @(posedge clk);
      #1;
      drv_grdy[d] = 1'b1;
    end
    cnt   = 0;
    guard = 0;
    while (guard < 64) begin
      @(negedge clk);
      if (!mon_gv[d]) break;
      cnt++;
      guard++;
    end
    check_eq("beats", 32'(cnt), 32'(beats));
    check_eq("req_ready_after", 32'(mon_rdy[d]), 32'd1);
  endtask

  initial begin
    #300000;
    $display("FAIL timeout: run still active at %0t, limit 300000ns", $time);
    $fatal(1);
  end

  initial begin
    int b;
    rst = 1'b1;
    for (int d = 0; d < 3; d++) begin
      drv_req[d]  = 16'h0;
      drv_vld[d]  = 1'b0;
      drv_grdy[d] = 1'b1;
    end
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int d = 0; d < 3; d++) begin
      check_eq("rst_gv",   32'(mon_gv[d]),   32'd0);
      check_eq("rst_rdy",  32'(mon_rdy[d]),  32'd1);
      check_eq("rst_idx",  32'(mon_idx[d]),  32'd0);
      check_eq("rst_oh",   32'(mon_oh[d]),   32'd0);
      check_eq("rst_none", 32'(mon_none[d]), 32'd0);
    end

    // Fixed priority: 7,5,2,1 back to back, then with a 5-cycle stall on the first grant.
    send(0, 16'b10100110, 0);
    send(0, 16'b10100110, 5);
    send(0, 16'h00, 0);

    // Reset while a grant is presented and bits are still pending.
    @(posedge clk); #1;
    drv_req[0]  = 16'b11110000;
    drv_vld[0]  = 1'b1;
    drv_grdy[0] = 1'b0;
    push_exp(0, 16'b11110000, b);
    @(posedge clk); #1;
    drv_vld[0] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("pre_rst_gv", 32'(mon_gv[0]), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sb0.delete();
    rr_ptr_m = 7;
    check_eq("midrst_gv",  32'(mon_gv[0]),  32'd0);
    check_eq("midrst_rdy", 32'(mon_rdy[0]), 32'd1);
    check_eq("midrst_idx", 32'(mon_idx[0]), 32'd0);
    check_eq("midrst_oh",  32'(mon_oh[0]),  32'd0);
    drv_grdy[0] = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check_eq("no_stale_gv", 32'(mon_gv[0]), 32'd0);
    end
    send(0, 16'b00000010, 0);

    // Round-robin: 4,0 then 7,4,0 with the wrap from pointer 0.
    send(1, 16'b00010001, 0);
    send(1, 16'b10010001, 0);
    send(1, 16'h00, 0);
    send(1, 16'b01000100, 2);

    // Single-bit sweep on the 16-wide instance.
    for (int i = 0; i < 16; i++) send(2, 16'd1 << i, 0);

    for (int k = 0; k < 6; k++) begin
      send(0, 16'($urandom_range(0, 255)), $urandom_range(0, 3));
      send(1, 16'($urandom_range(0, 255)), $urandom_range(0, 3));
      send(2, 16'($urandom_range(0, 65535)), $urandom_range(0, 2));
    end

    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) check_eq("sb_drained", 32'(sb_size(d)), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
